wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Shares the general register file's single write-back port (wb, wb_r, result) among N_REQ execution-unit requesters.
- Each requester has a one-entry holding slot; a round-robin arbiter grants one slot per cycle.
- Outputs are registered and drive the register file's write-back inputs directly.
- Sits between the execute-stage units and the 16-entry register file. Only a write-back clears a register's reservation, so every accepted request must eventually be written.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- W_OPR, 32, operand/result width; must match the register file.
- W_RD, 4, register index width (16 registers).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- req_valid_i  input  N_REQ  per-requester write-back request.
- req_rd_i  input  N_REQ*W_RD  destination register; requester i occupies bits [i*W_RD +: W_RD].
- req_data_i  input  N_REQ*W_OPR  result data; requester i occupies bits [i*W_OPR +: W_OPR].
- req_ready_o  output  N_REQ  slot i can accept this cycle.
- wb_o  output  1  write-back strobe to the register file.
- wb_r_o  output  W_RD  write-back register index.
- result_o  output  W_OPR  write-back data.
- busy_o  output  1  OR of all slot-valid bits.

Behaviour:
- Reset (async, reset==0):
  - all slot_valid = 0; rr_ptr = 0.
  - wb_o = 0, wb_r_o = 0, result_o = 0; busy_o = 0.
  - A reset mid-operation discards pending slots with no write-back.
- Handshake:
  - Transfer on requester i occurs when req_valid_i[i] & req_ready_o[i] at a rising edge.
  - req_ready_o[i] = ~slot_valid[i] | grant[i]. This path is combinational from slot state only; there is no path from req_valid_i.
- Slot update per edge, for each i:
  - transfer → slot loads rd/data and stays valid. This covers the simultaneous grant-and-refill case, which gives one write-back per cycle per requester.
  - else grant[i] → slot_valid[i] = 0.
  - else hold.
- Arbitration: combinational over slot_valid.
  - Search starts at index rr_ptr, ascending with wrap-around modulo N_REQ.
  - The first valid slot wins; grant is one-hot or zero.
  - On a grant to k: rr_ptr <= (k+1) mod N_REQ. With no grant, rr_ptr holds.
- Output stage (registered):
  - wb_o <= |grant; wb_r_o/result_o <= the winning slot's rd/data.
  - With no grant, wb_o <= 0 and wb_r_o/result_o hold their previous values.
  - wb_o is high for exactly one cycle per granted slot.
- Latency, uncontested: request accepted at edge E0 → granted in the cycle after E0 → wb_o high in the cycle following edge E0+1.
- Throughput: one write-back per cycle in total. Each requester can sustain one per cycle when uncontested.
- Fairness: under continuous contention, a valid slot waits at most N_REQ-1 grants.
- Ordering:
  - Per requester, order is preserved.
  - Across requesters, order follows arbitration only.
  - Two pending slots with the same rd are legal; they are written in grant order.
- busy_o = |slot_valid (combinational).

Optional Feature:
- Macro: WB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins. rr_ptr is removed and the fairness bound does not apply; a starved slot may wait indefinitely.
- Undefined (default): round-robin as above.
- All ports, latency and handshake are identical in both builds.

Decomposition:
- Shared params package/include: W_OPR, W_RD, REG_S (=16), default N_REQ.
- Sub-module wb_rr_arbiter:
  - Inputs: clk, reset, req vector (slot_valid).
  - Outputs: one-hot grant.
  - Holds rr_ptr internally.
  - WB_FIXED_PRIO_EN is handled inside this sub-module.
- wb_arbiter holds the slots, handshake and output registers.

Test Plan:
- Reset during traffic: fill slots 0 and 2, assert reset=0 for 1 cycle → busy_o=0, wb_o=0, wb_r_o=0, result_o=0; no write-back for either slot after reset release.
- Single uncontested: req 1, rd=5, data=0xDEADBEEF accepted at edge E0 → wb_o=1, wb_r_o=5, result_o=0xDEADBEEF for exactly one cycle after E0+1; req_ready_o[1] stays 1 throughout.
- Round-robin contention: all 4 slots loaded the same cycle, each requester writing rd = its own index → write-back order r0,r1,r2,r3 on 4 consecutive cycles. Reload all 4 → order r0,r1,r2,r3 again (rr_ptr back at 0); with WB_FIXED_PRIO_EN, r0 is always first.
- Starvation bound: requesters 0 and 1 valid every cycle, requester 3 loads once → r3 is written within 4 cycles of acceptance. With WB_FIXED_PRIO_EN, r3 waits until 0 and 1 go idle.
- Back-to-back single requester: req 2 valid 8 consecutive cycles with data 1..8 → 8 consecutive wb_o cycles, result_o 1..8 in order, req_ready_o[2] never low.
- Same-rd collision: req 0 and req 3 both write rd=7 (data 0xA, 0xB) the same cycle with rr_ptr=0 → two write-backs to r7, 0xA then 0xB.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg: shared widths for the write-back arbiter and register file
package wb_arbiter_pkg;
  localparam int W_OPR     = 32;
  localparam int W_RD      = 4;
  localparam int REG_S     = 16;
  localparam int N_REQ_DEF = 4;
endpackage

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: one-hot round-robin grant over slot_valid (WB_FIXED_PRIO_EN selects lowest-index priority)
module wb_rr_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant
);
`ifdef WB_FIXED_PRIO_EN
  always_comb begin
    grant = '0;
    for (int i = 0; i < N_REQ; i++)
      if (~|grant && req[i]) grant[i] = 1'b1;
  end
`else
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  logic [PW-1:0] rr_ptr, nxt_ptr;
  logic [PW:0]   k;
  always_comb begin
    grant = '0;
    k = '0;
    for (int j = 0; j < N_REQ; j++) begin
      k = {1'b0, rr_ptr} + (PW+1)'(j);
      k = (k >= (PW+1)'(N_REQ)) ? k - (PW+1)'(N_REQ) : k;
      if (~|grant && req[k[PW-1:0]]) grant[k[PW-1:0]] = 1'b1;
    end
  end
  always_comb begin
    nxt_ptr = rr_ptr;
    for (int i = 0; i < N_REQ; i++)
      if (grant[i]) nxt_ptr = (i == N_REQ - 1) ? '0 : PW'(i + 1);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) rr_ptr <= '0;
    else rr_ptr <= nxt_ptr;
`endif
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: per-requester holding slots feeding the register file write-back port (WB_FIXED_PRIO_EN in wb_rr_arbiter)
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int W_OPR = wb_arbiter_pkg::W_OPR,
  parameter int W_RD  = wb_arbiter_pkg::W_RD
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid_i,
  input  logic [N_REQ*W_RD-1:0]  req_rd_i,
  input  logic [N_REQ*W_OPR-1:0] req_data_i,
  output logic [N_REQ-1:0]       req_ready_o,
  output logic                   wb_o,
  output logic [W_RD-1:0]        wb_r_o,
  output logic [W_OPR-1:0]       result_o,
  output logic                   busy_o
);
  logic [N_REQ-1:0] slot_valid, grant, xfer;
  logic [W_RD-1:0]  slot_rd   [N_REQ];
  logic [W_OPR-1:0] slot_data [N_REQ];
  logic [W_RD-1:0]  win_rd;
  logic [W_OPR-1:0] win_data;
  assign req_ready_o = ~slot_valid | grant;
  assign xfer        = req_valid_i & req_ready_o;
  assign busy_o      = |slot_valid;
  wb_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (slot_valid),
    .grant (grant)
  );
  always_comb begin
    win_rd   = '0;
    win_data = '0;
    for (int i = 0; i < N_REQ; i++)
      if (grant[i]) begin
        win_rd   = slot_rd[i];
        win_data = slot_data[i];
      end
  end
  // a refill on the granting edge keeps the slot valid, giving one write-back per cycle
  always_ff @(posedge clk or negedge reset)
    if (!reset) slot_valid <= '0;
    else slot_valid <= xfer | (slot_valid & ~grant);
  always_ff @(posedge clk)
    for (int i = 0; i < N_REQ; i++)
      if (xfer[i]) begin
        slot_rd[i]   <= req_rd_i[i*W_RD +: W_RD];
        slot_data[i] <= req_data_i[i*W_OPR +: W_OPR];
      end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wb_o     <= 1'b0;
      wb_r_o   <= '0;
      result_o <= '0;
    end else begin
      wb_o <= |grant;
      if (|grant) begin
        wb_r_o   <= win_rd;
        result_o <= win_data;
      end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed self-checking bench for wb_arbiter (round-robin build)
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;
  localparam int N = 4;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [N-1:0]       req_valid_i = '0;
  logic [N*W_RD-1:0]  req_rd_i = '0;
  logic [N*W_OPR-1:0] req_data_i = '0;
  logic [N-1:0]       req_ready_o;
  logic               wb_o, busy_o;
  logic [W_RD-1:0]    wb_r_o;
  logic [W_OPR-1:0]   result_o;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  wb_arbiter #(.N_REQ(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid_i (req_valid_i),
    .req_rd_i    (req_rd_i),
    .req_data_i  (req_data_i),
    .req_ready_o (req_ready_o),
    .wb_o        (wb_o),
    .wb_r_o      (wb_r_o),
    .result_o    (result_o),
    .busy_o      (busy_o)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
  endtask
  task automatic drive(input int i, input logic [W_RD-1:0] rd, input logic [W_OPR-1:0] d);
    req_valid_i[i] = 1'b1;
    req_rd_i[i*W_RD +: W_RD] = rd;
    req_data_i[i*W_OPR +: W_OPR] = d;
  endtask
  task automatic expect_wb(input string tag, input logic [W_RD-1:0] rd, input logic [W_OPR-1:0] d);
    check({tag, "_wb"}, 64'(wb_o), 64'd1);
    check({tag, "_rd"}, 64'(wb_r_o), 64'(rd));
    check({tag, "_data"}, 64'(result_o), 64'(d));
  endtask
  task automatic drain(input string tag);
    for (int c = 0; c < 12 && busy_o; c++) step();
    step();
    check({tag, "_idle"}, 64'(busy_o), 64'd0);
    check({tag, "_nowb"}, 64'(wb_o), 64'd0);
  endtask
  initial begin
    step();
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_wb", 64'(wb_o), 64'd0);
    check("rst_rd", 64'(wb_r_o), 64'd0);
    check("rst_data", 64'(result_o), 64'd0);
    check("rst_ready", 64'(req_ready_o), 64'hF);
    reset = 1'b1;
    step();
    // all four at once, twice: rr_ptr returns to 0 so order is 0..3 both rounds
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < N; i++) drive(i, W_RD'(i), W_OPR'(32'h100 + 16 * r + i));
      step();
      req_valid_i = '0;
      check("rr_busy", 64'(busy_o), 64'd1);
      for (int i = 0; i < N; i++) begin
        step();
        expect_wb($sformatf("rr%0d_%0d", r, i), W_RD'(i), W_OPR'(32'h100 + 16 * r + i));
      end
      step();
      check("rr_end_wb", 64'(wb_o), 64'd0);
    end
    drive(0, 4'd7, 32'hA);
    drive(3, 4'd7, 32'hB);
    step();
    req_valid_i = '0;
    step();
    expect_wb("same_rd_a", 4'd7, 32'hA);
    step();
    expect_wb("same_rd_b", 4'd7, 32'hB);
    step();
    check("same_rd_end", 64'(wb_o), 64'd0);
    drive(1, 4'd5, 32'hDEADBEEF);
    check("one_rdy0", 64'(req_ready_o[1]), 64'd1);
    step();
    req_valid_i = '0;
    check("one_rdy1", 64'(req_ready_o[1]), 64'd1);
    check("one_early", 64'(wb_o), 64'd0);
    step();
    check("one_rdy2", 64'(req_ready_o[1]), 64'd1);
    expect_wb("one", 4'd5, 32'hDEADBEEF);
    step();
    check("one_single", 64'(wb_o), 64'd0);
    for (int i = 1; i <= 8; i++) begin
      drive(2, 4'd2, W_OPR'(i));
      check($sformatf("b2b_rdy%0d", i), 64'(req_ready_o[2]), 64'd1);
      step();
      if (i >= 2) expect_wb($sformatf("b2b%0d", i - 1), 4'd2, W_OPR'(i - 1));
    end
    req_valid_i = '0;
    step();
    expect_wb("b2b8", 4'd2, 32'd8);
    step();
    check("b2b_end", 64'(wb_o), 64'd0);
    begin
      int seen;
      logic [W_OPR-1:0] seen_data;
      seen = 0;
      seen_data = '0;
      drive(0, 4'd0, 32'h10);
      drive(1, 4'd1, 32'h11);
      drive(3, 4'd3, 32'h30);
      step();
      req_valid_i[3] = 1'b0;
      for (int c = 1; c <= 12 && seen == 0; c++) begin
        step();
        if (wb_o && wb_r_o == 4'd3) begin
          seen = c;
          seen_data = result_o;
        end
      end
      check("starve_bound", 64'(seen >= 1 && seen <= 4), 64'd1);
      check("starve_data", 64'(seen_data), 64'h30);
      req_valid_i = '0;
      drain("starve");
    end
    drive(0, 4'd9, 32'h55);
    drive(2, 4'd12, 32'h66);
    step();
    req_valid_i = '0;
    check("mid_busy_pre", 64'(busy_o), 64'd1);
    reset = 1'b0;
    #1;
    check("mid_busy", 64'(busy_o), 64'd0);
    check("mid_wb", 64'(wb_o), 64'd0);
    check("mid_rd", 64'(wb_r_o), 64'd0);
    check("mid_data", 64'(result_o), 64'd0);
    step();
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      check($sformatf("mid_nowb%0d", c), 64'(wb_o), 64'd0);
    end
    check("mid_idle", 64'(busy_o), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
